arbiter_out_node: RTL and testbench
===================================

# arbiter_out_node

Outbound arbiter of the communication assist. Collects packets from the three upload register sets (inst cache, data cache, memory) and multiplexes them onto the node's outgoing request and reply channels toward the OUT_req / OUT_rep FIFOs of the ring router. It runs two independent wormhole FSMs, one per channel, each with round-robin arbitration at packet-head granularity. Once a channel grants a source, that channel stays locked to the source until the source's tail flit is accepted.

## Interface
Parameters:
- FLIT_W, 16, flit width
- Ctrl encoding (fixed): 2'b01 head, 2'b10 body, 2'b11 tail, 2'b00 idle

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- v_ic  in  1  inst-cache upload flit valid. The inst cache sends requests only.
- flit_ic  in  16  inst-cache flit.
- ctrl_ic  in  2  inst-cache flit ctrl.
- v_dc / flit_dc / ctrl_dc  in  1/16/2  data-cache upload flit.
- dc_is_rep  in  1  data-cache packet type, sampled with its head: 1 = reply, 0 = request.
- v_mem / flit_mem / ctrl_mem  in  1/16/2  memory upload flit.
- mem_is_rep  in  1  memory packet type, sampled with its head.
- out_req_rdy  in  1  OUT_req FIFO can accept a flit.
- out_rep_rdy  in  1  OUT_rep FIFO can accept a flit.
- ack_ic / ack_dc / ack_mem  out  1  the source's current flit is consumed this cycle.
- v_req_out / flit_req_out / ctrl_req_out  out  1/16/2  request-channel flit.
- v_rep_out / flit_rep_out / ctrl_rep_out  out  1/16/2  reply-channel flit.

## Operation
- Packets are at least 2 flits: head (01), zero or more body (10), then tail (11).
- A source presents one packet at a time. Its type input must stay stable from head through tail.

Request FSM, one-hot states: req_idle, req_ic_up, req_dc_up, req_mem_up.
- In req_idle, a candidate is a source with v=1, ctrl=01 and type request. The inst cache is always type request.
- Pick the candidate with highest round-robin priority, but only if out_req_rdy=1.
- On a pick: transfer the head, pulse that source's ack, move to the source's _up state, and rotate priority so the winner becomes lowest.
- In req_X_up: when v_X=1 and out_req_rdy=1, transfer the flit and pulse ack_X. If its ctrl=11, return to req_idle.

Reply FSM, one-hot states: rep_idle, rep_dc_up, rep_mem_up.
- Same rules as the request FSM, using out_rep_rdy, with candidates dc and mem of type reply.

Common rules:
- The two FSMs run concurrently. A request from one source and a reply from the other may transfer in the same cycle.
- A source is consumed by at most one channel per cycle; this holds because a source presents one packet at a time.
- Round-robin reset priority: request channel ic > dc > mem; reply channel dc > mem. The pointer updates only on a head grant.
- A flit with ctrl 10 or 11 arriving while its channel is idle is not a head. It is ignored: no ack, no output.
- While a channel is locked, the other sources' flits on that channel are not acked. They wait with their inputs held.
- Output muxing is combinational. When a channel is not transferring, its v, flit and ctrl outputs are all 0.

## Timing
- Zero-cycle path: v_X, flit_X, ctrl_X and out_*_rdy drive v_*_out, flit_*_out and ack_X in the same cycle.
- Only the state and round-robin pointer registers are clocked.
- Transfer condition: v_*_out=1 with its rdy=1 at the clock edge. ack_X equals this condition exactly.
- A stall (v_X=0 or rdy=0) holds the state. There is no timeout.
- Throughput: 1 flit/cycle/channel. An n-flit packet takes n cycles with no stalls.
- A new head can be granted on the cycle right after a tail.
- Reset (rst=0 at posedge): both FSMs go to idle and both pointers return to their reset priority.
  - Reset takes effect even mid-packet; the partial packet is abandoned.
  - During reset and in the following idle cycle, all ack and out outputs are 0.
- Simultaneous heads on a channel: exactly one is granted, per the pointer. The others see ack=0.

## Test plan
- ic 3-flit request (01, 10, 11), out_req_rdy=1 → v_req_out high for 3 cycles with flits passed through unchanged; ack_ic high for 3 cycles; FSM back to req_idle.
- ic, dc and mem request heads all asserted from reset, rdy=1, each packet 2 flits → grant order ic, dc, mem. A repeat of the same three-way contention is granted dc, mem, ic only if ic won last; check the pointer rotates.
- dc reply and mem request simultaneously → both channels transfer in the same cycles; ack_dc=1 and ack_mem=1 together.
- out_rep_rdy=0 for 2 cycles during the body of a mem reply → v_rep_out and ack_mem stay 0 during the stall. Flits are neither lost nor duplicated, and the tail is delivered after rdy returns.
- Stray tail (ctrl=11) from dc while rep_idle → no ack, v_rep_out=0, state unchanged.
- rst=0 asserted mid-packet in req_dc_up → next cycle req_idle. A new ic head is then granted ahead of dc because priority was reset.

Source files
------------

// File: rtl/arbiter_out_node.sv
// Outbound arbiter: merges ic/dc/mem upload flits onto the request and reply channels
// using two independent wormhole FSMs with packet-granular round-robin arbitration.
module arbiter_out_node #(
    parameter int unsigned FlitW = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             v_ic_i,
    input  logic [FlitW-1:0] flit_ic_i,
    input  logic [1:0]       ctrl_ic_i,
    input  logic             v_dc_i,
    input  logic [FlitW-1:0] flit_dc_i,
    input  logic [1:0]       ctrl_dc_i,
    input  logic             dc_is_rep_i,
    input  logic             v_mem_i,
    input  logic [FlitW-1:0] flit_mem_i,
    input  logic [1:0]       ctrl_mem_i,
    input  logic             mem_is_rep_i,
    input  logic             out_req_rdy_i,
    input  logic             out_rep_rdy_i,
    output logic             ack_ic_o,
    output logic             ack_dc_o,
    output logic             ack_mem_o,
    output logic             v_req_out_o,
    output logic [FlitW-1:0] flit_req_out_o,
    output logic [1:0]       ctrl_req_out_o,
    output logic             v_rep_out_o,
    output logic [FlitW-1:0] flit_rep_out_o,
    output logic [1:0]       ctrl_rep_out_o
);

    localparam logic [1:0] CtrlHead = 2'b01;
    localparam logic [1:0] CtrlTail = 2'b11;

    typedef enum logic [3:0] {
        ReqIdle  = 4'b0001,
        ReqIcUp  = 4'b0010,
        ReqDcUp  = 4'b0100,
        ReqMemUp = 4'b1000
    } req_state_e;

    typedef enum logic [2:0] {
        RepIdle  = 3'b001,
        RepDcUp  = 3'b010,
        RepMemUp = 3'b100
    } rep_state_e;

    req_state_e req_state_q, req_state_d;
    rep_state_e rep_state_q, rep_state_d;
    // Pointers hold the index of the currently highest-priority source.
    logic [1:0] req_rr_q, req_rr_d;
    logic       rep_rr_q, rep_rr_d;

    // Source views, indexed ic = 0, dc = 1, mem = 2.
    logic [2:0]            src_v;
    logic [2:0][FlitW-1:0] src_flit;
    logic [2:0][1:0]       src_ctrl;

    assign src_v    = {v_mem_i, v_dc_i, v_ic_i};
    assign src_flit = {flit_mem_i, flit_dc_i, flit_ic_i};
    assign src_ctrl = {ctrl_mem_i, ctrl_dc_i, ctrl_ic_i};

    logic [2:0] req_cand;
    logic [1:0] rep_cand;

    assign req_cand[0] = v_ic_i && (ctrl_ic_i == CtrlHead);
    assign req_cand[1] = v_dc_i && (ctrl_dc_i == CtrlHead) && !dc_is_rep_i;
    assign req_cand[2] = v_mem_i && (ctrl_mem_i == CtrlHead) && !mem_is_rep_i;
    assign rep_cand[0] = v_dc_i && (ctrl_dc_i == CtrlHead) && dc_is_rep_i;
    assign rep_cand[1] = v_mem_i && (ctrl_mem_i == CtrlHead) && mem_is_rep_i;

    logic       req_found;
    logic [1:0] req_win;
    logic [2:0] req_idx;

    always_comb begin
        req_found = 1'b0;
        req_win   = 2'd0;
        req_idx   = 3'd0;
        for (int k = 0; k < 3; k++) begin
            req_idx = {1'b0, req_rr_q} + 3'(k);
            if (req_idx >= 3'd3) begin
                req_idx = req_idx - 3'd3;
            end
            if (!req_found && req_cand[req_idx[1:0]]) begin
                req_found = 1'b1;
                req_win   = req_idx[1:0];
            end
        end
    end

    logic rep_found;
    logic rep_win;

    assign rep_found = |rep_cand;
    assign rep_win   = rep_cand[rep_rr_q] ? rep_rr_q : !rep_rr_q;

    logic [1:0] req_sel, rep_sel;
    logic       req_xfer, rep_xfer;

    always_comb begin
        req_state_d = req_state_q;
        req_rr_d    = req_rr_q;
        req_sel     = 2'd0;
        req_xfer    = 1'b0;
        unique case (req_state_q)
            ReqIdle: begin
                if (req_found && out_req_rdy_i) begin
                    req_sel  = req_win;
                    req_xfer = 1'b1;
                    req_rr_d = (req_win == 2'd2) ? 2'd0 : req_win + 2'd1;
                    unique case (req_win)
                        2'd0:    req_state_d = ReqIcUp;
                        2'd1:    req_state_d = ReqDcUp;
                        default: req_state_d = ReqMemUp;
                    endcase
                end
            end
            ReqIcUp, ReqDcUp, ReqMemUp: begin
                req_sel = {req_state_q[3], req_state_q[2]};
                if (src_v[req_sel] && out_req_rdy_i) begin
                    req_xfer = 1'b1;
                    if (src_ctrl[req_sel] == CtrlTail) begin
                        req_state_d = ReqIdle;
                    end
                end
            end
            default: req_state_d = ReqIdle;
        endcase
    end

    always_comb begin
        rep_state_d = rep_state_q;
        rep_rr_d    = rep_rr_q;
        rep_sel     = 2'd1;
        rep_xfer    = 1'b0;
        unique case (rep_state_q)
            RepIdle: begin
                if (rep_found && out_rep_rdy_i) begin
                    rep_sel     = rep_win ? 2'd2 : 2'd1;
                    rep_xfer    = 1'b1;
                    rep_rr_d    = !rep_win;
                    rep_state_d = rep_win ? RepMemUp : RepDcUp;
                end
            end
            RepDcUp, RepMemUp: begin
                rep_sel = rep_state_q[2] ? 2'd2 : 2'd1;
                if (src_v[rep_sel] && out_rep_rdy_i) begin
                    rep_xfer = 1'b1;
                    if (src_ctrl[rep_sel] == CtrlTail) begin
                        rep_state_d = RepIdle;
                    end
                end
            end
            default: rep_state_d = RepIdle;
        endcase
    end

    // Outputs are forced quiet while reset is asserted, whatever the inputs show.
    logic       req_go, rep_go;
    logic [2:0] req_ack, rep_ack;

    assign req_go  = req_xfer && rst_ni;
    assign rep_go  = rep_xfer && rst_ni;
    assign req_ack = req_go ? (3'b001 << req_sel) : 3'b000;
    assign rep_ack = rep_go ? (3'b001 << rep_sel) : 3'b000;

    assign ack_ic_o  = req_ack[0] || rep_ack[0];
    assign ack_dc_o  = req_ack[1] || rep_ack[1];
    assign ack_mem_o = req_ack[2] || rep_ack[2];

    assign v_req_out_o    = req_go;
    assign flit_req_out_o = req_go ? src_flit[req_sel] : '0;
    assign ctrl_req_out_o = req_go ? src_ctrl[req_sel] : 2'b00;
    assign v_rep_out_o    = rep_go;
    assign flit_rep_out_o = rep_go ? src_flit[rep_sel] : '0;
    assign ctrl_rep_out_o = rep_go ? src_ctrl[rep_sel] : 2'b00;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            req_state_q <= ReqIdle;
            rep_state_q <= RepIdle;
            req_rr_q    <= 2'd0;
            rep_rr_q    <= 1'b0;
        end else begin
            req_state_q <= req_state_d;
            rep_state_q <= rep_state_d;
            req_rr_q    <= req_rr_d;
            rep_rr_q    <= rep_rr_d;
        end
    end

endmodule

// File: tb/tb_arbiter_out_node.sv
// Self-checking bench for arbiter_out_node: per-cycle stimulus tables, expected flits queued
// per channel when driven and compared when the channel is expected to transfer.
module tb_arbiter_out_node;

    localparam logic [1:0] HD = 2'b01;
    localparam logic [1:0] BD = 2'b10;
    localparam logic [1:0] TL = 2'b11;

    // Expected {ack_ic, ack_dc, ack_mem, v_req_out, v_rep_out}
    localparam logic [4:0] E_NONE    = 5'b00000;
    localparam logic [4:0] E_IC_REQ  = 5'b10010;
    localparam logic [4:0] E_DC_REQ  = 5'b01010;
    localparam logic [4:0] E_MEM_REQ = 5'b00110;
    localparam logic [4:0] E_DC_REP  = 5'b01001;
    localparam logic [4:0] E_MEM_REP = 5'b00101;
    localparam logic [4:0] E_BOTH    = 5'b01111;

    localparam logic [1:0] S_IC  = 2'd0;
    localparam logic [1:0] S_DC  = 2'd1;
    localparam logic [1:0] S_MEM = 2'd2;
    localparam logic       P_DC  = 1'b0;
    localparam logic       P_MEM = 1'b1;

    typedef struct packed {
        logic        v;
        logic        rep;
        logic [1:0]  ctrl;
        logic [15:0] flit;
    } src_t;

    typedef struct packed {
        logic       rst_n;
        logic       rq;
        logic       rp;
        src_t       ic;
        src_t       dc;
        src_t       mem;
        logic [4:0] want;
        logic [1:0] rs;
        logic       ps;
    } cyc_t;

    localparam src_t IDL = '0;

    logic        clk, rst_n;
    logic        v_ic, v_dc, v_mem, dc_is_rep, mem_is_rep;
    logic [15:0] flit_ic, flit_dc, flit_mem;
    logic [1:0]  ctrl_ic, ctrl_dc, ctrl_mem;
    logic        out_req_rdy, out_rep_rdy;
    logic        ack_ic, ack_dc, ack_mem;
    logic        v_req_out, v_rep_out;
    logic [15:0] flit_req_out, flit_rep_out;
    logic [1:0]  ctrl_req_out, ctrl_rep_out;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [17:0] req_q[$];
    logic [17:0] rep_q[$];

    arbiter_out_node #(.FlitW(16)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .v_ic_i         (v_ic),
        .flit_ic_i      (flit_ic),
        .ctrl_ic_i      (ctrl_ic),
        .v_dc_i         (v_dc),
        .flit_dc_i      (flit_dc),
        .ctrl_dc_i      (ctrl_dc),
        .dc_is_rep_i    (dc_is_rep),
        .v_mem_i        (v_mem),
        .flit_mem_i     (flit_mem),
        .ctrl_mem_i     (ctrl_mem),
        .mem_is_rep_i   (mem_is_rep),
        .out_req_rdy_i  (out_req_rdy),
        .out_rep_rdy_i  (out_rep_rdy),
        .ack_ic_o       (ack_ic),
        .ack_dc_o       (ack_dc),
        .ack_mem_o      (ack_mem),
        .v_req_out_o    (v_req_out),
        .flit_req_out_o (flit_req_out),
        .ctrl_req_out_o (ctrl_req_out),
        .v_rep_out_o    (v_rep_out),
        .flit_rep_out_o (flit_rep_out),
        .ctrl_rep_out_o (ctrl_rep_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    function automatic src_t fl(logic [1:0] ctrl, logic [15:0] flit, logic rep = 1'b0);
        return {1'b1, rep, ctrl, flit};
    endfunction

    function automatic cyc_t cy(logic rq, logic rp, src_t ic, src_t dc, src_t mem,
                                logic [4:0] want, logic [1:0] rs = S_IC, logic ps = P_DC,
                                logic rn = 1'b1);
        return {rn, rq, rp, ic, dc, mem, want, rs, ps};
    endfunction

    function automatic logic [4:0] flags();
        return {ack_ic, ack_dc, ack_mem, v_req_out, v_rep_out};
    endfunction

    // Drives one cycle of stimulus and queues the flits each channel should carry.
    task automatic apply(input cyc_t t);
        src_t s;
        rst_n       = t.rst_n;
        out_req_rdy = t.rq;
        out_rep_rdy = t.rp;
        v_ic        = t.ic.v;
        ctrl_ic     = t.ic.ctrl;
        flit_ic     = t.ic.flit;
        v_dc        = t.dc.v;
        ctrl_dc     = t.dc.ctrl;
        flit_dc     = t.dc.flit;
        dc_is_rep   = t.dc.rep;
        v_mem       = t.mem.v;
        ctrl_mem    = t.mem.ctrl;
        flit_mem    = t.mem.flit;
        mem_is_rep  = t.mem.rep;
        if (t.want[1]) begin
            s = (t.rs == S_IC) ? t.ic : (t.rs == S_DC) ? t.dc : t.mem;
            req_q.push_back({s.ctrl, s.flit});
        end
        if (t.want[0]) begin
            s = (t.ps == P_MEM) ? t.mem : t.dc;
            rep_q.push_back({s.ctrl, s.flit});
        end
    endtask

    task automatic test_reset();
        cyc_t        tbl[$];
        logic [17:0] wq, wp;
        tbl.push_back(cy(1, 1, fl(HD, 16'h0a00), fl(HD, 16'h0d00), fl(HD, 16'h0e00, 1),
                         E_NONE, S_IC, P_DC, 1'b0));
        tbl.push_back(cy(1, 1, fl(HD, 16'h0a00), fl(HD, 16'h0d00), fl(HD, 16'h0e00, 1),
                         E_NONE, S_IC, P_DC, 1'b0));
        tbl.push_back(cy(1, 1, IDL, IDL, IDL, E_NONE));
        foreach (tbl[i]) begin
            apply(tbl[i]);
            @(negedge clk);
            wq = tbl[i].want[1] ? req_q.pop_front() : 18'd0;
            wp = tbl[i].want[0] ? rep_q.pop_front() : 18'd0;
            checks++;
            if (flags() !== tbl[i].want) begin
                errors++;
                $display("FAIL reset[%0d] flags got %b want %b", i, flags(), tbl[i].want);
            end
            checks++;
            if ({ctrl_req_out, flit_req_out} !== wq) begin
                errors++;
                $display("FAIL reset[%0d] req got %h want %h", i, {ctrl_req_out, flit_req_out}, wq);
            end
            checks++;
            if ({ctrl_rep_out, flit_rep_out} !== wp) begin
                errors++;
                $display("FAIL reset[%0d] rep got %h want %h", i, {ctrl_rep_out, flit_rep_out}, wp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_ic_packet();
        cyc_t        tbl[$];
        logic [17:0] wq, wp;
        tbl.push_back(cy(1, 1, fl(HD, 16'ha100), IDL, IDL, E_IC_REQ, S_IC));
        tbl.push_back(cy(1, 1, fl(BD, 16'ha101), IDL, IDL, E_IC_REQ, S_IC));
        tbl.push_back(cy(1, 1, fl(TL, 16'ha102), IDL, IDL, E_IC_REQ, S_IC));
        // Back in idle: a dc request head is granted the very next cycle.
        tbl.push_back(cy(1, 1, IDL, fl(HD, 16'hb100), IDL, E_DC_REQ, S_DC));
        tbl.push_back(cy(1, 1, IDL, fl(TL, 16'hb101), IDL, E_DC_REQ, S_DC));
        foreach (tbl[i]) begin
            apply(tbl[i]);
            @(negedge clk);
            wq = tbl[i].want[1] ? req_q.pop_front() : 18'd0;
            wp = tbl[i].want[0] ? rep_q.pop_front() : 18'd0;
            checks++;
            if (flags() !== tbl[i].want) begin
                errors++;
                $display("FAIL ic_packet[%0d] flags got %b want %b", i, flags(), tbl[i].want);
            end
            checks++;
            if ({ctrl_req_out, flit_req_out} !== wq) begin
                errors++;
                $display("FAIL ic_packet[%0d] req got %h want %h", i,
                         {ctrl_req_out, flit_req_out}, wq);
            end
            checks++;
            if ({ctrl_rep_out, flit_rep_out} !== wp) begin
                errors++;
                $display("FAIL ic_packet[%0d] rep got %h want %h", i,
                         {ctrl_rep_out, flit_rep_out}, wp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_round_robin();
        cyc_t        tbl[$];
        logic [17:0] wq, wp;
        tbl.push_back(cy(1, 1, IDL, IDL, IDL, E_NONE, S_IC, P_DC, 1'b0));
        tbl.push_back(cy(1, 1, fl(HD, 16'ha110), fl(HD, 16'hb110), fl(HD, 16'hc110),
                         E_IC_REQ, S_IC));
        tbl.push_back(cy(1, 1, fl(TL, 16'ha111), fl(HD, 16'hb110), fl(HD, 16'hc110),
                         E_IC_REQ, S_IC));
        tbl.push_back(cy(1, 1, fl(HD, 16'ha120), fl(HD, 16'hb110), fl(HD, 16'hc110),
                         E_DC_REQ, S_DC));
        tbl.push_back(cy(1, 1, fl(HD, 16'ha120), fl(TL, 16'hb111), fl(HD, 16'hc110),
                         E_DC_REQ, S_DC));
        tbl.push_back(cy(1, 1, fl(HD, 16'ha120), fl(HD, 16'hb120), fl(HD, 16'hc110),
                         E_MEM_REQ, S_MEM));
        tbl.push_back(cy(1, 1, fl(HD, 16'ha120), fl(HD, 16'hb120), fl(TL, 16'hc111),
                         E_MEM_REQ, S_MEM));
        tbl.push_back(cy(1, 1, fl(HD, 16'ha120), fl(HD, 16'hb120), fl(HD, 16'hc120),
                         E_IC_REQ, S_IC));
        tbl.push_back(cy(1, 1, fl(TL, 16'ha121), fl(HD, 16'hb120), fl(HD, 16'hc120),
                         E_IC_REQ, S_IC));
        tbl.push_back(cy(1, 1, IDL, fl(HD, 16'hb120), fl(HD, 16'hc120), E_DC_REQ, S_DC));
        tbl.push_back(cy(1, 1, IDL, fl(TL, 16'hb121), fl(HD, 16'hc120), E_DC_REQ, S_DC));
        tbl.push_back(cy(1, 1, IDL, IDL, fl(HD, 16'hc120), E_MEM_REQ, S_MEM));
        tbl.push_back(cy(1, 1, IDL, IDL, fl(TL, 16'hc121), E_MEM_REQ, S_MEM));
        foreach (tbl[i]) begin
            apply(tbl[i]);
            @(negedge clk);
            wq = tbl[i].want[1] ? req_q.pop_front() : 18'd0;
            wp = tbl[i].want[0] ? rep_q.pop_front() : 18'd0;
            checks++;
            if (flags() !== tbl[i].want) begin
                errors++;
                $display("FAIL round_robin[%0d] flags got %b want %b", i, flags(), tbl[i].want);
            end
            checks++;
            if ({ctrl_req_out, flit_req_out} !== wq) begin
                errors++;
                $display("FAIL round_robin[%0d] req got %h want %h", i,
                         {ctrl_req_out, flit_req_out}, wq);
            end
            checks++;
            if ({ctrl_rep_out, flit_rep_out} !== wp) begin
                errors++;
                $display("FAIL round_robin[%0d] rep got %h want %h", i,
                         {ctrl_rep_out, flit_rep_out}, wp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_concurrent();
        cyc_t        tbl[$];
        logic [17:0] wq, wp;
        tbl.push_back(cy(1, 1, IDL, fl(HD, 16'hd200, 1), fl(HD, 16'hc200), E_BOTH, S_MEM, P_DC));
        tbl.push_back(cy(1, 1, IDL, fl(BD, 16'hd201, 1), fl(TL, 16'hc201), E_BOTH, S_MEM, P_DC));
        tbl.push_back(cy(1, 1, IDL, fl(TL, 16'hd202, 1), IDL, E_DC_REP, S_IC, P_DC));
        foreach (tbl[i]) begin
            apply(tbl[i]);
            @(negedge clk);
            wq = tbl[i].want[1] ? req_q.pop_front() : 18'd0;
            wp = tbl[i].want[0] ? rep_q.pop_front() : 18'd0;
            checks++;
            if (flags() !== tbl[i].want) begin
                errors++;
                $display("FAIL concurrent[%0d] flags got %b want %b", i, flags(), tbl[i].want);
            end
            checks++;
            if ({ctrl_req_out, flit_req_out} !== wq) begin
                errors++;
                $display("FAIL concurrent[%0d] req got %h want %h", i,
                         {ctrl_req_out, flit_req_out}, wq);
            end
            checks++;
            if ({ctrl_rep_out, flit_rep_out} !== wp) begin
                errors++;
                $display("FAIL concurrent[%0d] rep got %h want %h", i,
                         {ctrl_rep_out, flit_rep_out}, wp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_stall();
        cyc_t        tbl[$];
        logic [17:0] wq, wp;
        tbl.push_back(cy(1, 1, IDL, IDL, fl(HD, 16'he300, 1), E_MEM_REP, S_IC, P_MEM));
        tbl.push_back(cy(1, 1, IDL, IDL, fl(BD, 16'he301, 1), E_MEM_REP, S_IC, P_MEM));
        tbl.push_back(cy(1, 0, IDL, fl(HD, 16'hd300, 1), fl(BD, 16'he302, 1), E_NONE));
        tbl.push_back(cy(1, 0, IDL, fl(HD, 16'hd300, 1), fl(BD, 16'he302, 1), E_NONE));
        tbl.push_back(cy(1, 1, IDL, fl(HD, 16'hd300, 1), fl(BD, 16'he302, 1),
                         E_MEM_REP, S_IC, P_MEM));
        tbl.push_back(cy(1, 1, IDL, fl(HD, 16'hd300, 1), fl(TL, 16'he303, 1),
                         E_MEM_REP, S_IC, P_MEM));
        tbl.push_back(cy(1, 1, IDL, fl(HD, 16'hd300, 1), IDL, E_DC_REP, S_IC, P_DC));
        tbl.push_back(cy(1, 1, IDL, fl(TL, 16'hd301, 1), IDL, E_DC_REP, S_IC, P_DC));
        tbl.push_back(cy(0, 1, fl(HD, 16'ha300), IDL, IDL, E_NONE));
        tbl.push_back(cy(1, 1, fl(HD, 16'ha300), IDL, IDL, E_IC_REQ, S_IC));
        tbl.push_back(cy(1, 1, fl(TL, 16'ha301), IDL, IDL, E_IC_REQ, S_IC));
        foreach (tbl[i]) begin
            apply(tbl[i]);
            @(negedge clk);
            wq = tbl[i].want[1] ? req_q.pop_front() : 18'd0;
            wp = tbl[i].want[0] ? rep_q.pop_front() : 18'd0;
            checks++;
            if (flags() !== tbl[i].want) begin
                errors++;
                $display("FAIL stall[%0d] flags got %b want %b", i, flags(), tbl[i].want);
            end
            checks++;
            if ({ctrl_req_out, flit_req_out} !== wq) begin
                errors++;
                $display("FAIL stall[%0d] req got %h want %h", i, {ctrl_req_out, flit_req_out}, wq);
            end
            checks++;
            if ({ctrl_rep_out, flit_rep_out} !== wp) begin
                errors++;
                $display("FAIL stall[%0d] rep got %h want %h", i, {ctrl_rep_out, flit_rep_out}, wp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_stray_tail();
        cyc_t        tbl[$];
        logic [17:0] wq, wp;
        tbl.push_back(cy(1, 1, fl(TL, 16'ha400), fl(TL, 16'hd400, 1), IDL, E_NONE));
        tbl.push_back(cy(1, 1, IDL, fl(BD, 16'hd401, 1), IDL, E_NONE));
        // Reply pointer favours mem here; a stray tail must not have locked dc.
        tbl.push_back(cy(1, 1, IDL, fl(HD, 16'hd402, 1), fl(HD, 16'he400, 1),
                         E_MEM_REP, S_IC, P_MEM));
        tbl.push_back(cy(1, 1, IDL, fl(HD, 16'hd402, 1), fl(TL, 16'he401, 1),
                         E_MEM_REP, S_IC, P_MEM));
        tbl.push_back(cy(1, 1, IDL, fl(HD, 16'hd402, 1), IDL, E_DC_REP, S_IC, P_DC));
        tbl.push_back(cy(1, 1, IDL, fl(TL, 16'hd403, 1), IDL, E_DC_REP, S_IC, P_DC));
        foreach (tbl[i]) begin
            apply(tbl[i]);
            @(negedge clk);
            wq = tbl[i].want[1] ? req_q.pop_front() : 18'd0;
            wp = tbl[i].want[0] ? rep_q.pop_front() : 18'd0;
            checks++;
            if (flags() !== tbl[i].want) begin
                errors++;
                $display("FAIL stray_tail[%0d] flags got %b want %b", i, flags(), tbl[i].want);
            end
            checks++;
            if ({ctrl_req_out, flit_req_out} !== wq) begin
                errors++;
                $display("FAIL stray_tail[%0d] req got %h want %h", i,
                         {ctrl_req_out, flit_req_out}, wq);
            end
            checks++;
            if ({ctrl_rep_out, flit_rep_out} !== wp) begin
                errors++;
                $display("FAIL stray_tail[%0d] rep got %h want %h", i,
                         {ctrl_rep_out, flit_rep_out}, wp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid_packet();
        cyc_t        tbl[$];
        logic [17:0] wq, wp;
        tbl.push_back(cy(1, 1, IDL, fl(HD, 16'hb500), IDL, E_DC_REQ, S_DC));
        tbl.push_back(cy(1, 1, IDL, fl(BD, 16'hb501), IDL, E_DC_REQ, S_DC));
        tbl.push_back(cy(1, 1, fl(HD, 16'ha500), fl(BD, 16'hb502), IDL, E_NONE, S_IC, P_DC, 1'b0));
        // Without a pointer reset mem would win here; without a state reset dc would.
        tbl.push_back(cy(1, 1, fl(HD, 16'ha500), fl(HD, 16'hb510), fl(HD, 16'hc500),
                         E_IC_REQ, S_IC));
        tbl.push_back(cy(1, 1, fl(TL, 16'ha501), fl(HD, 16'hb510), fl(HD, 16'hc500),
                         E_IC_REQ, S_IC));
        tbl.push_back(cy(1, 1, IDL, fl(HD, 16'hb510), fl(HD, 16'hc500), E_DC_REQ, S_DC));
        tbl.push_back(cy(1, 1, IDL, fl(TL, 16'hb511), fl(HD, 16'hc500), E_DC_REQ, S_DC));
        tbl.push_back(cy(1, 1, IDL, IDL, fl(HD, 16'hc500), E_MEM_REQ, S_MEM));
        tbl.push_back(cy(1, 1, IDL, IDL, fl(TL, 16'hc501), E_MEM_REQ, S_MEM));
        tbl.push_back(cy(1, 1, IDL, IDL, IDL, E_NONE));
        foreach (tbl[i]) begin
            apply(tbl[i]);
            @(negedge clk);
            wq = tbl[i].want[1] ? req_q.pop_front() : 18'd0;
            wp = tbl[i].want[0] ? rep_q.pop_front() : 18'd0;
            checks++;
            if (flags() !== tbl[i].want) begin
                errors++;
                $display("FAIL reset_mid[%0d] flags got %b want %b", i, flags(), tbl[i].want);
            end
            checks++;
            if ({ctrl_req_out, flit_req_out} !== wq) begin
                errors++;
                $display("FAIL reset_mid[%0d] req got %h want %h", i,
                         {ctrl_req_out, flit_req_out}, wq);
            end
            checks++;
            if ({ctrl_rep_out, flit_rep_out} !== wp) begin
                errors++;
                $display("FAIL reset_mid[%0d] rep got %h want %h", i,
                         {ctrl_rep_out, flit_rep_out}, wp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        out_req_rdy = 1'b0;
        out_rep_rdy = 1'b0;
        v_ic        = 1'b0;
        flit_ic     = '0;
        ctrl_ic     = 2'b00;
        v_dc        = 1'b0;
        flit_dc     = '0;
        ctrl_dc     = 2'b00;
        dc_is_rep   = 1'b0;
        v_mem       = 1'b0;
        flit_mem    = '0;
        ctrl_mem    = 2'b00;
        mem_is_rep  = 1'b0;
        #1;
        test_reset();
        test_ic_packet();
        test_round_robin();
        test_concurrent();
        test_stall();
        test_stray_tail();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
